// File: rtl/tile_sequencer.sv
// tile_sequencer: walks a framebuffer tile by tile, alternating raster and tile-writer starts.
// Ports:
//   gpu_clk, gpu_rst       clock, asynchronous active-high reset
//   start, abort           begin a frame / stop issuing tiles and drain
//   cfg_base, cfg_stride   frame base address and row pitch (bytes), latched on accepted start
//   cfg_tiles_x/y          frame size in tiles, latched on accepted start
//   raster_busy            raster_controller is busy
//   writer_reading         tile_writer is still reading tile RAM
//   writer_flushed         tile_writer FIFO fully drained to SDRAM
//   tile_start, tile_x/y   raster pulse with the tile coordinates
//   write_start            writer pulse with write_addr, write_stride
//   busy, done, aborted    frame status
//   tiles_written          write_start pulses issued in this frame
module tile_sequencer #(
   parameter int TILE_DIM = 32,
   parameter int BPP      = 2,
   parameter int TCW      = 8
) (
   input  logic             gpu_clk,
   input  logic             gpu_rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      cfg_base,
   input  logic [15:0]      cfg_stride,
   input  logic [TCW-1:0]   cfg_tiles_x,
   input  logic [TCW-1:0]   cfg_tiles_y,
   input  logic             raster_busy,
   input  logic             writer_reading,
   input  logic             writer_flushed,
   output logic             tile_start,
   output logic [TCW-1:0]   tile_x,
   output logic [TCW-1:0]   tile_y,
   output logic             write_start,
   output logic [31:0]      write_addr,
   output logic [15:0]      write_stride,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [2*TCW-1:0] tiles_written
);
   typedef enum logic [2:0] {IDLE, R_ISSUE, R_ARM, R_WAIT, W_ISSUE, W_ARM, FLUSH, DONE} state_t;
   localparam int          TSH   = $clog2(TILE_DIM);
   localparam logic [31:0] TSTEP = 32'(TILE_DIM * BPP);
   state_t         state;
   logic [31:0]    row_base, col_addr, row_step;
   logic [TCW-1:0] tiles_x, tiles_y, tx, ty;
   logic           abort_pending, last, stop, row_end;
   // write_stride doubles as the latched stride; TILE_DIM*stride is a pure shift
   assign row_step = {16'b0, write_stride} << TSH;
   // an abort takes effect in the very cycle it is sampled
   assign stop     = abort | abort_pending;
   assign row_end  = tx == tiles_x - 1'b1;
   always_ff @(posedge gpu_clk or posedge gpu_rst) begin
      if (gpu_rst) begin
         state         <= IDLE;
         row_base      <= '0;
         col_addr      <= '0;
         tiles_x       <= '0;
         tiles_y       <= '0;
         tx            <= '0;
         ty            <= '0;
         abort_pending <= 1'b0;
         last          <= 1'b0;
         tile_start    <= 1'b0;
         tile_x        <= '0;
         tile_y        <= '0;
         write_start   <= 1'b0;
         write_addr    <= '0;
         write_stride  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         aborted       <= 1'b0;
         tiles_written <= '0;
      end else begin
         tile_start  <= 1'b0;
         write_start <= 1'b0;
         done        <= 1'b0;
         if (abort && state != IDLE) abort_pending <= 1'b1;
         case (state)
            IDLE: if (start) begin
               write_stride  <= cfg_stride;
               tiles_x       <= cfg_tiles_x;
               tiles_y       <= cfg_tiles_y;
               busy          <= 1'b1;
               tiles_written <= '0;
               aborted       <= 1'b0;
               abort_pending <= 1'b0;
               row_base      <= cfg_base;
               col_addr      <= cfg_base;
               tx            <= '0;
               ty            <= '0;
               state         <= (cfg_tiles_x == '0 || cfg_tiles_y == '0) ? DONE : R_ISSUE;
            end
            R_ISSUE: if (!raster_busy) begin
               if (stop) state <= FLUSH;
               else begin
                  tile_start <= 1'b1;
                  tile_x     <= tx;
                  tile_y     <= ty;
                  state      <= R_ARM;
               end
            end
            // raster_busy may lag tile_start by a cycle
            R_ARM:  state <= R_WAIT;
            // a tile aborted mid-raster is allowed to finish but is never written
            R_WAIT: if (!raster_busy) state <= stop ? FLUSH : W_ISSUE;
            W_ISSUE: begin
               if (stop) begin
                  if (!raster_busy) state <= FLUSH;
               end else if (!writer_reading && !raster_busy) begin
                  write_start   <= 1'b1;
                  write_addr    <= col_addr;
                  tiles_written <= tiles_written + 1'b1;
                  last          <= row_end && ty == tiles_y - 1'b1;
                  if (row_end) begin
                     tx       <= '0;
                     ty       <= ty + 1'b1;
                     row_base <= row_base + row_step;
                     col_addr <= row_base + row_step;
                  end else begin
                     tx       <= tx + 1'b1;
                     col_addr <= col_addr + TSTEP;
                  end
                  state <= W_ARM;
               end
            end
            // the next raster overlaps the writer draining this tile
            W_ARM:  state <= last ? FLUSH : R_ISSUE;
            FLUSH:  if (writer_flushed && !writer_reading) state <= DONE;
            DONE: begin
               done          <= 1'b1;
               busy          <= 1'b0;
               aborted       <= abort_pending;
               abort_pending <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
